fwd_hazard_unit: RTL
====================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter STALL_CNT_WIDTH, default 32, width of the stall event counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port id_valid, input, 1, ID stage holds a real instruction.
REQ-005 SHALL have port id_rs1, input, `REG_ADDR_WIDTH, ID source register 1.
REQ-006 SHALL have port id_rs2, input, `REG_ADDR_WIDTH, ID source register 2.
REQ-007 SHALL have port id_rs1_used, input, 1, ID instruction reads rs1.
REQ-008 SHALL have port id_rs2_used, input, 1, ID instruction reads rs2.
REQ-009 SHALL have port id_rd, input, `REG_ADDR_WIDTH, ID destination register.
REQ-010 SHALL have port id_reg_write, input, 1, ID instruction writes rd.
REQ-011 SHALL have port id_mem_read, input, 1, ID instruction is a load.
REQ-012 SHALL have port flush, input, 1, branch/jump taken in EX; kill ID instruction.
REQ-013 SHALL have port forward_op1, output, `FORWARD_WIDTH, registered operand-1 select for the instruction in EX.
REQ-014 SHALL have port forward_op2, output, `FORWARD_WIDTH, registered operand-2 select for the instruction in EX.
REQ-015 SHALL have port stall_id, output, 1, combinational; hold PC and IF/ID this cycle.
REQ-016 SHALL have port ex_bubble, output, 1, registered; EX holds an inserted bubble.
REQ-017 SHALL have port stall_count, output, STALL_CNT_WIDTH, number of load-use stall cycles.

Function
REQ-018 SHALL track two internal entries, EX and MEM, each {valid, rd, reg_write, mem_read}.
REQ-019 SHALL on every non-reset edge shift MEM <= EX.
REQ-020 SHALL load EX <= ID fields when id_valid & !stall_id & !flush, else EX <= bubble (valid=0).
REQ-021 SHALL register ex_bubble = 1 exactly when a bubble entered EX because of stall_id or flush; it SHALL be 0 for plain !id_valid.
REQ-022 SHALL define a match on rsN as: entry.valid & entry.reg_write & entry.rd != 0 & entry.rd == id_rsN & id_rsN_used.
REQ-023 SHALL register forward_opN on the edge the ID instruction enters EX as: `FORWARD_MEM if current EX entry matches; else `FORWARD_WB if current MEM entry matches; else `FORWARD_NONE.
REQ-024 SHALL prioritise `FORWARD_MEM over `FORWARD_WB when both entries match (newest producer wins).
REQ-025 SHALL register forward_op1/op2 = `FORWARD_NONE whenever a bubble enters EX.
REQ-026 SHALL assert stall_id = !rst & !flush & id_valid & EX.mem_read & (rs1 match on EX | rs2 match on EX) (load-use hazard).
REQ-027 SHALL give flush priority over stall_id; a flushed ID instruction never stalls.
REQ-028 SHALL produce exactly one stall cycle per load-use hazard; after it the load sits in MEM and the consumer enters EX with `FORWARD_WB.
REQ-029 SHALL NOT forward from an instruction already in WB; the register file is write-first and resolves WB-to-ID reads.
REQ-030 SHALL increment stall_count by 1 on each edge where stall_id=1, wrapping to 0 at all-ones.
REQ-031 SHALL keep all outputs free of X when ID inputs are X while id_valid=0.

Reset
REQ-032 SHALL on an edge with rst=1 clear EX and MEM valid, set forward_op1/op2=`FORWARD_NONE, ex_bubble=0, stall_count=0.
REQ-033 SHALL hold stall_id=0 while rst=1, including reset asserted mid-stall.
REQ-034 SHALL accept a valid ID instruction on the first edge after rst deasserts.

Verification
REQ-035 SHALL pass: add x5 (EX), then ID add x6,x5,x7 -> next cycle forward_op1=`FORWARD_MEM, forward_op2=`FORWARD_NONE, stall_id=0.
REQ-036 SHALL pass: lw x5 in EX, ID add x6,x1,x5 -> stall_id=1 one cycle, ex_bubble=1, stall_count=1; next edge forward_op2=`FORWARD_WB.
REQ-037 SHALL pass: x5 written by both EX and MEM entries, ID reads x5 on rs1 and rs2 -> both selects `FORWARD_MEM.
REQ-038 SHALL pass: producer rd=x0 with reg_write=1, ID reads x0 -> forwards `FORWARD_NONE, no stall even for a load.
REQ-039 SHALL pass: load-use hazard with flush=1 in the same cycle -> stall_id=0, bubble enters EX, ex_bubble=1, stall_count unchanged.
REQ-040 SHALL pass: rst=1 during a stall cycle -> stall_id=0 immediately; after the edge all selects `FORWARD_NONE, stall_count=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage in-order pipeline.
// Shadows the EX and MEM destination info, registers the operand forwarding
// selects for the instruction entering EX, and detects load-use stalls.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef FORWARD_WIDTH
`define FORWARD_WIDTH 2
`endif
`ifndef FORWARD_NONE
`define FORWARD_NONE 2'b00
`endif
`ifndef FORWARD_MEM
`define FORWARD_MEM 2'b01
`endif
`ifndef FORWARD_WB
`define FORWARD_WB 2'b10
`endif

module fwd_hazard_unit #(
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [`REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [`REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [`REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_mem_read,
  input  logic                       flush,
  output logic [`FORWARD_WIDTH-1:0]  forward_op1,
  output logic [`FORWARD_WIDTH-1:0]  forward_op2,
  output logic                       stall_id,
  output logic                       ex_bubble,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam logic [`REG_ADDR_WIDTH-1:0] REG_ZERO = {`REG_ADDR_WIDTH{1'b0}};
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE  = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ZERO = {STALL_CNT_WIDTH{1'b0}};

  // EX entry: the instruction currently in EX.
  logic                       ex_valid_q, ex_valid_d;
  logic [`REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                       ex_reg_write_q, ex_reg_write_d;
  logic                       ex_mem_read_q, ex_mem_read_d;

  // MEM entry: a load in MEM already has its data for the WB bypass, so its
  // mem_read flag is never consulted and is not kept.
  logic                       mem_valid_q;
  logic [`REG_ADDR_WIDTH-1:0] mem_rd_q;
  logic                       mem_reg_write_q;

  logic [`FORWARD_WIDTH-1:0]  fwd1_q, fwd1_d;
  logic [`FORWARD_WIDTH-1:0]  fwd2_q, fwd2_d;
  logic                       bubble_q, bubble_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic rs1_ex_match_s, rs2_ex_match_s;
  logic rs1_mem_match_s, rs2_mem_match_s;
  logic stall_s;
  logic load_ex_s;

  // A producer entry feeds a consumer source only for a real, writing,
  // non-x0 destination that the consumer actually reads.
  function automatic logic entry_match(
    input logic                       valid,
    input logic                       reg_write,
    input logic [`REG_ADDR_WIDTH-1:0] rd,
    input logic [`REG_ADDR_WIDTH-1:0] rs,
    input logic                       rs_used
  );
    entry_match = valid & reg_write & (rd != REG_ZERO) & (rd == rs) & rs_used;
  endfunction

  // Select source: newest producer (EX) wins over the older one (MEM).
  function automatic logic [`FORWARD_WIDTH-1:0] pick_fwd(
    input logic ex_hit,
    input logic mem_hit
  );
    if (ex_hit) begin
      pick_fwd = `FORWARD_MEM;
    end else if (mem_hit) begin
      pick_fwd = `FORWARD_WB;
    end else begin
      pick_fwd = `FORWARD_NONE;
    end
  endfunction

  // Hazard detection and next-state computation for all tracked state.
  always_comb begin
    rs1_ex_match_s  = entry_match(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs1, id_rs1_used);
    rs2_ex_match_s  = entry_match(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs2, id_rs2_used);
    rs1_mem_match_s = entry_match(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs1, id_rs1_used);
    rs2_mem_match_s = entry_match(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs2, id_rs2_used);

    // Flush and reset both override the load-use stall.
    stall_s   = ~rst & ~flush & id_valid & ex_mem_read_q & (rs1_ex_match_s | rs2_ex_match_s);
    load_ex_s = id_valid & ~stall_s & ~flush;

    ex_valid_d     = 1'b0;
    ex_rd_d        = REG_ZERO;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    fwd1_d         = `FORWARD_NONE;
    fwd2_d         = `FORWARD_NONE;

    if (load_ex_s) begin
      ex_valid_d     = 1'b1;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write;
      ex_mem_read_d  = id_mem_read;
      fwd1_d         = pick_fwd(rs1_ex_match_s, rs1_mem_match_s);
      fwd2_d         = pick_fwd(rs2_ex_match_s, rs2_mem_match_s);
    end else begin
      ex_valid_d     = 1'b0;
      ex_rd_d        = REG_ZERO;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end

    // Only an instruction killed or held back counts as an inserted bubble.
    bubble_d = stall_s | (flush & id_valid);

    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Pipeline shadow, forwarding selects and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= REG_ZERO;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= REG_ZERO;
      mem_reg_write_q <= 1'b0;
      fwd1_q          <= `FORWARD_NONE;
      fwd2_q          <= `FORWARD_NONE;
      bubble_q        <= 1'b0;
      stall_cnt_q     <= CNT_ZERO;
    end else begin
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      fwd1_q          <= fwd1_d;
      fwd2_q          <= fwd2_d;
      bubble_q        <= bubble_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign forward_op1 = fwd1_q;
  assign forward_op2 = fwd2_q;
  assign stall_id    = stall_s;
  assign ex_bubble   = bubble_q;
  assign stall_count = stall_cnt_q;

endmodule
